// File: rtl/amm_rd_master_if.sv
// Avalon-MM read-master bundle: command input, Avalon read port, streaming output and status.
interface amm_rd_master_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BYTE_CNT   = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH  = 12
);
  logic                  cmd_valid;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_length;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] amm_address;
  logic                  amm_read;
  logic [BYTE_CNT-1:0]   amm_byteenable;
  logic                  amm_waitrequest;
  logic [DATA_WIDTH-1:0] amm_readdata;
  logic                  amm_readdatavalid;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_length,
    output cmd_ready,
    output amm_address, amm_read, amm_byteenable,
    input  amm_waitrequest, amm_readdata, amm_readdatavalid,
    output out_valid, out_data,
    input  out_ready,
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_length,
    input  cmd_ready,
    input  amm_address, amm_read, amm_byteenable,
    output amm_waitrequest, amm_readdata, amm_readdatavalid,
    input  out_valid, out_data,
    output out_ready,
    input  busy, done
  );
endinterface

// File: rtl/amm_rd_master.sv
// Avalon-MM pipelined single-word read master; returned words are buffered in a credited FIFO
// and streamed out in issue order.
module amm_rd_master #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BYTE_CNT   = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH  = 12,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  amm_rd_master_if.master   bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]      pend_q, pend_d;
  logic [CNT_W-1:0]      used_q, used_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  rd_q, rd_d;
  logic                  ovalid_q, cmd_ready_q, busy_q, done_q;
  logic                  err_q, err_d;
  logic                  accept, push, pop;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Next-state, credit and FIFO pointer logic
  always_comb begin
    accept   = rd_q & ~bus.amm_waitrequest;
    push     = bus.amm_readdatavalid & (pend_q != '0);
    pop      = ovalid_q & bus.out_ready;
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    pend_d   = pend_q + CNT_W'(accept) - CNT_W'(push);
    used_d   = used_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    err_d    = err_q | (bus.amm_readdatavalid & (pend_q == '0));

    if (accept) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      rem_d  = rem_q - LEN_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_length;
          state_d = (bus.cmd_length == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: if (accept && rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
      S_DRAIN: if (pend_d == '0 && used_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A stalled request is held; a new one needs a free FIFO slot counting reads in flight
    rd_d = (state_d == S_ISSUE) && (rem_d != '0) &&
           (({1'b0, pend_d} + {1'b0, used_d}) < SUM_W'(FIFO_DEPTH));
    if (rd_q && bus.amm_waitrequest) rd_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      pend_q      <= '0;
      used_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_q        <= 1'b0;
      ovalid_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      pend_q      <= pend_d;
      used_q      <= used_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_q        <= rd_d;
      ovalid_q    <= (used_d != '0);
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      err_q       <= err_d;
    end
  end

  // Return-data storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.amm_readdata;
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.amm_address    = addr_q;
  assign bus.amm_read       = rd_q;
  assign bus.amm_byteenable = {BYTE_CNT{rd_q}};
  assign bus.out_valid      = ovalid_q;
  assign bus.out_data       = ovalid_q ? mem[rd_ptr_q] : '0;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
endmodule

// File: tb/tb_amm_rd_master.sv
// Directed bench for amm_rd_master: behavioural Avalon slave with programmable latency/stalls
// and a recording sink; expected addresses/data are computed from the command parameters.
`timescale 1ns/1ps
module tb_amm_rd_master;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 10;
  localparam int unsigned BC = 8;
  localparam int unsigned LW = 12;
  localparam int unsigned FD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  amm_rd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_CNT(BC), .LEN_WIDTH(LW)) bus ();

  amm_rd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_CNT(BC), .LEN_WIDTH(LW),
                  .FIFO_DEPTH(FD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int due; logic [AW-1:0] addr; } beat_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  beat_t infl[$];
  logic [AW-1:0] acc_addr[$];
  logic [DW-1:0] got[$];
  int lat_min = 1, lat_max = 1, last_due = 0;
  int stall_idx = -1, stall_left = 0, stall_seen = 0, hold_err = 0;
  logic [AW-1:0] stall_addr = '0;
  logic stall_prev = 1'b0;
  int rd_cycles = 0, ov_cycles = 0, done_cnt = 0, done_cyc = -1, last_pop_cyc = -1;
  int first_acc_cyc = -1, last_acc_cyc = -1, first_ov_cyc = -1;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {16'hDA7A, 6'b0, a, 22'h0, a};
  endfunction

  // Slave and sink model, evaluated mid-cycle so the decisions apply to the next posedge
  always @(negedge clk) begin
    int lat, due;
    cyc++;
    if (stall_prev && (!bus.amm_read || bus.amm_address != stall_addr)) hold_err++;
    if (bus.amm_read && acc_addr.size() == stall_idx && stall_left > 0) begin
      bus.amm_waitrequest = 1'b1;
      stall_left--;
      stall_seen++;
      stall_addr = bus.amm_address;
      stall_prev = 1'b1;
    end else begin
      bus.amm_waitrequest = 1'b0;
      stall_prev = 1'b0;
    end
    if (bus.amm_read) rd_cycles++;
    if (bus.amm_read && !bus.amm_waitrequest) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      infl.push_back('{due, bus.amm_address});
      acc_addr.push_back(bus.amm_address);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    if (infl.size() > 0 && infl[0].due <= cyc) begin
      bus.amm_readdatavalid = 1'b1;
      bus.amm_readdata = data_of(infl[0].addr);
      infl.delete(0);
    end else begin
      bus.amm_readdatavalid = 1'b0;
      bus.amm_readdata = '0;
    end
    if (bus.out_valid) begin
      ov_cycles++;
      if (first_ov_cyc < 0) first_ov_cyc = cyc;
    end
    if (bus.out_valid && bus.out_ready) begin
      got.push_back(bus.out_data);
      last_pop_cyc = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    acc_addr.delete();
    got.delete();
    rd_cycles = 0; ov_cycles = 0; done_cnt = 0; done_cyc = -1; last_pop_cyc = -1;
    stall_seen = 0; hold_err = 0; first_acc_cyc = -1; last_acc_cyc = -1; first_ov_cyc = -1;
  endtask

  task automatic start_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = a;
    bus.cmd_length = n;
    tick(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    chk({tag, "_cmd_ready_after_done"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, "_done_pulse_low"}, 64'(bus.done), 64'd0);
  endtask

  task automatic check_stream(input string tag, input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    chk({tag, "_n_reads"}, 64'(acc_addr.size()), 64'(len));
    chk({tag, "_n_words"}, 64'(got.size()), 64'(len));
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      if (i < acc_addr.size()) chk($sformatf("%s_addr%0d", tag, i), 64'(acc_addr[i]), 64'(a));
      if (i < got.size()) chk($sformatf("%s_data%0d", tag, i), got[i], data_of(a));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, "_amm_read"}, 64'(bus.amm_read), 64'd0);
    chk({tag, "_amm_address"}, 64'(bus.amm_address), 64'd0);
    chk({tag, "_byteenable"}, 64'(bus.amm_byteenable), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_data"}, bus.out_data, 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_length = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check_reset_outs("reset");
    rst_n = 1'b1;
    tick(2);

    // T1: back-to-back reads, latency 1
    clear_rec();
    start_cmd(10'h010, 12'd4);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    chk("t1_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
    chk("t1_byteenable", 64'(bus.amm_byteenable), 64'hFF);
    wait_done("t1", 100);
    check_stream("t1", 10'h010, 4);
    chk("t1_b2b_span", 64'(last_acc_cyc - first_acc_cyc), 64'd3);
    chk("t1_rd_cycles", 64'(rd_cycles), 64'd4);
    chk("t1_rdv_to_out_latency", 64'(first_ov_cyc - first_acc_cyc), 64'd2);
    chk("t1_done_after_last_pop", 64'(done_cyc - last_pop_cyc), 64'd1);
    chk("t1_done_cycle", 64'(done_cyc - first_acc_cyc), 64'd6);
    tick(3);
    chk("t1_single_done", 64'(done_cnt), 64'd1);

    // T2: 3-cycle stall on the second read
    clear_rec();
    stall_idx = 1;
    stall_left = 3;
    start_cmd(10'h010, 12'd4);
    wait_done("t2", 100);
    check_stream("t2", 10'h010, 4);
    chk("t2_stall_cycles", 64'(stall_seen), 64'd3);
    chk("t2_stall_addr", 64'(stall_addr), 64'h011);
    chk("t2_hold_err", 64'(hold_err), 64'd0);
    chk("t2_rd_cycles", 64'(rd_cycles), 64'd7);
    stall_idx = -1;

    // T3: sink stalled, credit limits outstanding reads to FIFO depth
    clear_rec();
    bus.out_ready = 1'b0;
    start_cmd(10'h020, 12'd20);
    tick(30);
    chk("t3_reads_under_backpressure", 64'(acc_addr.size()), 64'd8);
    chk("t3_amm_read_off", 64'(bus.amm_read), 64'd0);
    chk("t3_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_head_data", bus.out_data, data_of(10'h020));
    chk("t3_busy", 64'(bus.busy), 64'd1);
    bus.out_ready = 1'b1;
    wait_done("t3", 300);
    check_stream("t3", 10'h020, 20);

    // T4: address wrap
    clear_rec();
    start_cmd(10'h3FE, 12'd4);
    wait_done("t4", 100);
    check_stream("t4", 10'h3FE, 4);

    // T5: zero-length command, then command issued while busy is ignored
    clear_rec();
    start_cmd(10'h155, 12'd0);
    chk("t5_len0_busy", 64'(bus.busy), 64'd1);
    wait_done("t5_len0", 10);
    tick(3);
    chk("t5_len0_no_reads", 64'(rd_cycles), 64'd0);
    chk("t5_len0_no_words", 64'(got.size()), 64'd0);
    chk("t5_len0_single_done", 64'(done_cnt), 64'd1);
    clear_rec();
    lat_min = 3;
    lat_max = 3;
    start_cmd(10'h100, 12'd3);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 10'h200;
    bus.cmd_length = 12'd5;
    tick(3);
    bus.cmd_valid = 1'b0;
    wait_done("t5_busy", 100);
    tick(8);
    check_stream("t5_busy", 10'h100, 3);
    chk("t5_busy_rd_cycles", 64'(rd_cycles), 64'd3);
    chk("t5_busy_idle", 64'(bus.busy), 64'd0);

    // T6: reset with reads in flight, random latency
    clear_rec();
    lat_min = 1;
    lat_max = 6;
    start_cmd(10'h080, 12'd12);
    n = 0;
    while (acc_addr.size() < 3 && n < 50) begin
      tick(1);
      n++;
    end
    chk("t6_three_issued", 64'(acc_addr.size() >= 3), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outs("t6_in_reset");
    tick(2);
    rst_n = 1'b1;
    clear_rec();
    tick(15);
    chk("t6_no_out_after_reset", 64'(ov_cycles), 64'd0);
    chk("t6_no_reads_after_reset", 64'(rd_cycles), 64'd0);
    check_reset_outs("t6_after_release");
    clear_rec();
    start_cmd(10'h040, 12'd5);
    wait_done("t6_clean", 200);
    check_stream("t6_clean", 10'h040, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
